// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed RV32 data memory with request/response handshake, fault detection and wait states
module dmem_lsu #(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int          AW    = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH = DEPTH_WORDS;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  state_t        state, state_n;
  logic [7:0]    cnt;
  logic          rdy, accept, err, legal, misaligned, out_of_range;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q, word, shifted, wd, ld;
  logic [3:0]    be;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [31:0]   mem [DEPTH_WORDS];
  assign req_ready    = rdy;
  assign accept       = req_valid && rdy;
  assign legal        = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                               : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  assign misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign out_of_range = {2'b00, req_addr[31:2]} >= DEPTH;
  assign err          = !legal || misaligned || out_of_range;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (accept) state_n = err ? RESP : (WAIT_STATES > 0 ? WAIT : ACCESS);
      WAIT:   if (cnt == 8'd0) state_n = ACCESS;
      ACCESS: state_n = RESP;
      RESP:   if (rsp_ready) state_n = IDLE;
    endcase
  end
  assign be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
              f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
              f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign word    = mem[addr_q[AW+1:2]];
  assign shifted = word >> {addr_q[1:0], 3'b000};
  assign b       = shifted[7:0];
  assign h       = addr_q[1] ? word[31:16] : word[15:0];
  assign ld      = f3_q == 3'd0 ? {{24{b[7]}}, b} :
                   f3_q == 3'd1 ? {{16{h[15]}}, h} :
                   f3_q == 3'd4 ? {24'd0, b} :
                   f3_q == 3'd5 ? {16'd0, h} : word;
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      rdy       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
    end else begin
      state <= state_n;
      rdy   <= state_n == IDLE;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        if (err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else if (WAIT_STATES > 0) begin
          cnt <= 8'(WAIT_STATES - 1);
        end
      end
      if (state == WAIT && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (state == ACCESS) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= we_q ? 32'd0 : ld;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random checks of dmem_lsu against a byte-level
// memory model, on one zero-wait and one three-wait-state instance.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_funct3[2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int failures = 0;
    int ws [2] = '{0, 3};
    logic [7:0] ref_mem [2][16384];

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_lsu #(.DEPTH_WORDS(4096), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, access size from funct3.
    task automatic model(input int i, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int   sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        logic legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        er = !legal || (addr % sz != 0) || (addr / 4 >= 4096);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int k = 0; k < sz; k++) ref_mem[i][int'(addr) + k] = 8'(wd >> (8 * k));
            end else begin
                for (int k = 0; k < sz; k++) rd |= 32'(ref_mem[i][int'(addr) + k]) << (8 * k);
                if (f3 < 4 && sz < 4 && rd[8*sz-1]) rd |= ~((32'd1 << (8 * sz)) - 32'd1);
            end
        end
    endtask

    task automatic do_op(input int i, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int k = 0;
        @(negedge clk);
        req_valid[i] = 1'b1; req_we[i] = we; req_funct3[i] = f3; req_addr[i] = addr; req_wdata[i] = wd;
        while (!req_ready[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        lat = 0;
        while (!rsp_valid[i] && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = rsp_rdata[i];
        er = rsp_err[i];
    endtask

    task automatic run(input int i, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag, output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        int          lat;
        model(i, we, f3, addr, wd, erd, eer);
        do_op(i, we, f3, addr, wd, rd, er, lat);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, 32'(er), 32'(eer));
        chk({tag, "_latency"}, lat, eer ? 0 : ws[i] + 1);
    endtask

    initial begin
        logic [31:0] rd, held, a;
        logic        er;
        int          r, i;
        for (int n = 0; n < 2; n++) begin
            rst_n[n] = 1'b0; req_valid[n] = 1'b0; req_we[n] = 1'b0; req_funct3[n] = 3'd0;
            req_addr[n] = 32'd0; req_wdata[n] = 32'd0; rsp_ready[n] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            chk("reset_rsp_valid", 32'(rsp_valid[n]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[n], 32'd0);
            chk("reset_rsp_err", 32'(rsp_err[n]), 32'd0);
            chk("reset_req_ready", 32'(req_ready[n]), 32'd0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 32'(req_ready[0]), 32'd1);

        for (int n = 0; n < 2; n++)
            for (int w = 0; w < 64; w++) run(n, 1'b1, 3'd2, 32'(w * 4), $urandom, "init_sw", rd, er);

        run(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10", rd, er);
        run(0, 1'b0, 3'd2, 32'h10, 32'd0, "lw_10", rd, er);
        chk("lw_10_const", rd, 32'hDEADBEEF);
        run(0, 1'b1, 3'd2, 32'h20, 32'd0, "sw_20", rd, er);
        run(0, 1'b1, 3'd0, 32'h21, 32'h7F, "sb_21", rd, er);
        run(0, 1'b0, 3'd2, 32'h20, 32'd0, "lw_20", rd, er);
        chk("lw_20_const", rd, 32'h00007F00);
        run(0, 1'b1, 3'd0, 32'h23, 32'hAB80, "sb_23", rd, er);
        run(0, 1'b0, 3'd0, 32'h23, 32'd0, "lb_23", rd, er);
        chk("lb_23_const", rd, 32'hFFFFFF80);
        run(0, 1'b0, 3'd4, 32'h23, 32'd0, "lbu_23", rd, er);
        chk("lbu_23_const", rd, 32'h00000080);
        run(0, 1'b1, 3'd1, 32'h32, 32'h12348001, "sh_32", rd, er);
        run(0, 1'b0, 3'd1, 32'h32, 32'd0, "lh_32", rd, er);
        chk("lh_32_const", rd, 32'hFFFF8001);
        run(0, 1'b0, 3'd5, 32'h32, 32'd0, "lhu_32", rd, er);
        chk("lhu_32_const", rd, 32'h00008001);
        run(0, 1'b0, 3'd1, 32'h31, 32'd0, "lh_31_misaligned", rd, er);
        chk("lh_31_err_const", 32'(er), 32'd1);
        run(0, 1'b1, 3'd1, 32'h31, 32'hFFFF, "sh_31_misaligned", rd, er);
        run(0, 1'b0, 3'd2, 32'h30, 32'd0, "lw_30_unchanged", rd, er);
        run(0, 1'b0, 3'd2, 32'h4000, 32'd0, "lw_4000_oor", rd, er);
        chk("lw_4000_err_const", 32'(er), 32'd1);
        run(0, 1'b0, 3'd2, 32'h3FFC, 32'd0, "lw_3ffc_last", rd, er);
        run(0, 1'b0, 3'd3, 32'h40, 32'd0, "load_f3_011", rd, er);
        chk("load_f3_011_err_const", 32'(er), 32'd1);
        run(0, 1'b1, 3'd4, 32'h40, 32'h55AA55AA, "store_f3_100", rd, er);
        chk("store_f3_100_err_const", 32'(er), 32'd1);
        run(0, 1'b0, 3'd2, 32'h40, 32'd0, "lw_40_unchanged", rd, er);

        rsp_ready[1] = 1'b0;
        run(1, 1'b0, 3'd2, 32'h10, 32'd0, "ws3_lw_hold", rd, er);
        held = rd;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata[1], held);
            chk("hold_req_ready", 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 chk("release_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("release_rsp_rdata", rsp_rdata[1], 32'd0);

        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h44; req_wdata[1] = ~{ref_mem[1][71], ref_mem[1][70], ref_mem[1][69], ref_mem[1][68]};
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        chk("rst_wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_wait_rsp_rdata", rsp_rdata[1], 32'd0);
        chk("rst_wait_rsp_err", 32'(rsp_err[1]), 32'd0);
        chk("rst_wait_req_ready", 32'(req_ready[1]), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        #1 chk("rst_release_ready_low", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        #1 chk("rst_release_ready_high", 32'(req_ready[1]), 32'd1);
        run(1, 1'b0, 3'd2, 32'h44, 32'd0, "lw_44_store_aborted", rd, er);

        for (int n = 0; n < 300; n++) begin
            i = n % 2;
            r = $urandom_range(0, 9);
            a = (r == 0) ? 32'h4000 + $urandom_range(0, 255) : (r == 1) ? $urandom : 32'($urandom_range(0, 255));
            run(i, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, "random", rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
